// File: rtl/regfile_input_ctrl.sv
// Pushbutton/switch conditioning front end for the 4-bit register file.
// Each clean press gives one single-cycle command strobe, with a registered operand p.
module regfile_input_ctrl #(
  parameter int DB_MAX = 500000,
  parameter int DB_W   = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn_rr1,
  input  logic       btn_rr2,
  input  logic       btn_wr,
  input  logic       btn_wdata,
  input  logic       btn_wen,
  output logic [3:0] p,
  output logic       setRR1,
  output logic       setRR2,
  output logic       setWR,
  output logic       setWData,
  output logic       Wenable,
  output logic       busy
);

  localparam int NB = 5;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_MAX - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  // Bit 0 is the highest-priority command; order matches the register file's decode.
  logic [NB-1:0] btn_raw;
  assign btn_raw = {btn_wen, btn_wdata, btn_wr, btn_rr2, btn_rr1};

  logic [NB-1:0] btn_s1, btn_s2;
  logic [3:0]    sw_s1, sw_s2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; a blocking chain here would collapse the synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  logic [NB-1:0] stable;
  logic [DB_W-1:0] cnt [NB];

  // NOTE: the counter array is small and its contents matter after reset (a held
  // button must restart its debounce), so every entry is reset, unlike a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (btn_s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          stable[i] <= ~stable[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t        state, state_nxt;
  logic [NB-1:0] strb_q, strb_nxt;
  logic          load_p;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    strb_nxt  = '0;
    load_p    = 1'b0;
    case (state)
      IDLE: begin
        if (|stable) begin
          state_nxt = HOLD;
          load_p    = 1'b1;
          // Scan downwards so the lowest set index (highest priority) wins.
          for (int i = NB - 1; i >= 0; i--) begin
            if (stable[i]) begin
              strb_nxt    = '0;
              strb_nxt[i] = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (!(|stable)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      strb_q <= '0;
      p      <= '0;
    end else begin
      state  <= state_nxt;
      strb_q <= strb_nxt;
      if (load_p) p <= sw_s2;
    end
  end

  assign setRR1   = strb_q[0];
  assign setRR2   = strb_q[1];
  assign setWR    = strb_q[2];
  assign setWData = strb_q[3];
  assign Wenable  = strb_q[4];
  assign busy     = (state == HOLD);

endmodule
